// File: rtl/muldiv_issue_arbiter.sv
// Round-robin arbiter sharing one mul/div unit between two issue ports.
// Tracks ownership of in-flight operations and steers results back to the owning port.
module muldiv_issue_arbiter #(
    parameter int DATA_W  = 256,
    parameter int XLEN    = 64,
    parameter int TID_W   = 3,
    parameter int MUL_LAT = 1,
    parameter int MAX_OUT = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic [1:0]          req_valid_i,
    input  logic [1:0]          req_is_div_i,
    input  logic [2*DATA_W-1:0] req_data_i,
    output logic [1:0]          req_ready_o,
    output logic                unit_valid_o,
    output logic [DATA_W-1:0]   unit_data_o,
    input  logic                unit_ready_i,
    input  logic                unit_result_valid_i,
    input  logic [XLEN-1:0]     unit_result_i,
    input  logic [TID_W-1:0]    unit_trans_id_i,
    output logic [1:0]          rsp_valid_o,
    output logic [XLEN-1:0]     rsp_result_o,
    output logic [TID_W-1:0]    rsp_trans_id_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int CW = $clog2(MAX_OUT + 1);

    logic                   rr_q, rr_d;
    logic [1:0][CW-1:0]     cnt_q, cnt_d;
    logic [MUL_LAT-1:0]     mul_vld_q, mul_vld_d;
    logic [MUL_LAT-1:0]     mul_port_q, mul_port_d;
    logic                   div_busy_q, div_busy_d;
    logic                   div_port_q, div_port_d;
    logic                   err_q, err_d;

    logic [1:0]             elig;
    logic [1:0]             grant;
    logic                   gnt_port;
    logic                   gnt_div;
    logic                   head_vld;
    logic                   head_port;
    logic                   err_set;

    assign head_vld  = mul_vld_q[MUL_LAT-1];
    assign head_port = mul_port_q[MUL_LAT-1];

    always_comb begin
        elig     = '0;
        grant    = '0;
        gnt_port = 1'b0;
        for (int p = 0; p < 2; p++) begin
            elig[p] = req_valid_i[p] && !flush_i && (cnt_q[p] < CW'(MAX_OUT))
                      && (req_is_div_i[p] ? (unit_ready_i && !div_busy_q) : 1'b1);
        end
        if (elig == 2'b11) begin
            gnt_port = rr_q;
        end else if (elig[1]) begin
            gnt_port = 1'b1;
        end
        if (|elig) begin
            grant[gnt_port] = 1'b1;
        end
    end

    assign gnt_div      = req_is_div_i[gnt_port];
    assign req_ready_o  = grant;
    assign unit_valid_o = |grant;
    assign unit_data_o  = !(|grant) ? '0 :
                          gnt_port  ? req_data_i[2*DATA_W-1:DATA_W] : req_data_i[DATA_W-1:0];

    // A multiply result always wins: the unit holds the divider result behind it.
    always_comb begin
        rsp_valid_o = '0;
        err_set     = 1'b0;
        if (unit_result_valid_i && !flush_i) begin
            if (head_vld) begin
                rsp_valid_o[head_port] = 1'b1;
            end else if (div_busy_q) begin
                rsp_valid_o[div_port_q] = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end
        if (head_vld && !unit_result_valid_i) begin
            err_set = 1'b1;
        end
    end

    assign rsp_result_o   = unit_result_i;
    assign rsp_trans_id_o = unit_trans_id_i;
    assign busy_o         = (cnt_q[0] != '0) || (cnt_q[1] != '0);
    assign err_o          = err_q;

    always_comb begin
        rr_d          = (|grant) ? ~gnt_port : rr_q;
        err_d         = err_q | err_set;
        mul_vld_d     = '0;
        mul_port_d    = '0;
        mul_vld_d[0]  = (|grant) && !gnt_div;
        mul_port_d[0] = gnt_port;
        for (int i = 1; i < MUL_LAT; i++) begin
            mul_vld_d[i]  = mul_vld_q[i-1];
            mul_port_d[i] = mul_port_q[i-1];
        end

        div_busy_d = div_busy_q;
        div_port_d = div_port_q;
        if (unit_result_valid_i && !head_vld) begin
            div_busy_d = 1'b0;
        end
        if ((|grant) && gnt_div) begin
            div_busy_d = 1'b1;
            div_port_d = gnt_port;
        end

        cnt_d = cnt_q;
        for (int p = 0; p < 2; p++) begin
            if (grant[p] && !rsp_valid_o[p]) begin
                cnt_d[p] = cnt_q[p] + CW'(1);
            end else if (!grant[p] && rsp_valid_o[p] && (cnt_q[p] != '0)) begin
                cnt_d[p] = cnt_q[p] - CW'(1);
            end
        end

        // Flush drops every in-flight operation; arbitration history and errors survive.
        if (flush_i) begin
            mul_vld_d  = '0;
            div_busy_d = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            mul_vld_q  <= '0;
            mul_port_q <= '0;
            div_busy_q <= 1'b0;
            div_port_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            mul_vld_q  <= mul_vld_d;
            mul_port_q <= mul_port_d;
            div_busy_q <= div_busy_d;
            div_port_q <= div_port_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Directed bench for muldiv_issue_arbiter: instance a uses MUL_LAT=1, instance b uses MUL_LAT=3.
// Request-side inputs are shared; each instance has its own result-valid strobe.
module tb_muldiv_issue_arbiter;

    localparam int DW = 64;
    localparam int XL = 64;
    localparam int TW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_is_div = '0;
    logic [2*DW-1:0] req_data = '0;
    logic            unit_ready = 1'b0;
    logic [XL-1:0]   res = '0;
    logic [TW-1:0]   tid = '0;
    logic            a_res_vld = 1'b0;
    logic            b_res_vld = 1'b0;

    logic [1:0]      a_ready, b_ready, a_rsp_vld, b_rsp_vld;
    logic            a_uvalid, b_uvalid, a_busy, b_busy, a_err, b_err;
    logic [DW-1:0]   a_udata, b_udata;
    logic [XL-1:0]   a_rsp_res, b_rsp_res;
    logic [TW-1:0]   a_rsp_tid, b_rsp_tid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_issue_arbiter #(.DATA_W(DW), .XLEN(XL), .TID_W(TW), .MUL_LAT(1), .MAX_OUT(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_is_div_i(req_is_div), .req_data_i(req_data),
        .req_ready_o(a_ready), .unit_valid_o(a_uvalid), .unit_data_o(a_udata),
        .unit_ready_i(unit_ready), .unit_result_valid_i(a_res_vld),
        .unit_result_i(res), .unit_trans_id_i(tid),
        .rsp_valid_o(a_rsp_vld), .rsp_result_o(a_rsp_res), .rsp_trans_id_o(a_rsp_tid),
        .busy_o(a_busy), .err_o(a_err)
    );

    muldiv_issue_arbiter #(.DATA_W(DW), .XLEN(XL), .TID_W(TW), .MUL_LAT(3), .MAX_OUT(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_is_div_i(req_is_div), .req_data_i(req_data),
        .req_ready_o(b_ready), .unit_valid_o(b_uvalid), .unit_data_o(b_udata),
        .unit_ready_i(unit_ready), .unit_result_valid_i(b_res_vld),
        .unit_result_i(res), .unit_trans_id_i(tid),
        .rsp_valid_o(b_rsp_vld), .rsp_result_o(b_rsp_res), .rsp_trans_id_o(b_rsp_tid),
        .busy_o(b_busy), .err_o(b_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_rsp", 64'(a_rsp_vld), 64'h0);
        check("rst_a_uvalid", 64'(a_uvalid), 64'h0);
        check("rst_a_busy", 64'(a_busy), 64'h0);
        check("rst_a_err", 64'(a_err), 64'h0);
        rst_n = 1'b1;
        unit_ready = 1'b1;
        req_data = {64'h2222, 64'h1111};

        // Single multiply on port 0, latency 1
        req_valid = 2'b01;
        #2;
        check("t1_ready", 64'(a_ready), 64'h1);
        check("t1_uvalid", 64'(a_uvalid), 64'h1);
        check("t1_udata", a_udata, 64'h1111);
        tick();
        req_valid = 2'b00; a_res_vld = 1'b1; res = 64'h2A; tid = 3'd5;
        #2;
        check("t1_rsp", 64'(a_rsp_vld), 64'h1);
        check("t1_res", a_rsp_res, 64'h2A);
        check("t1_tid", 64'(a_rsp_tid), 64'h5);
        check("t1_udata_idle", a_udata, 64'h0);
        tick();
        a_res_vld = 1'b0;
        #2;
        check("t1_busy", 64'(a_busy), 64'h0);

        // Port 1 alone first so both-port contention starts with rr at port 0
        req_valid = 2'b10;
        #2;
        check("t2_pre_ready", 64'(a_ready), 64'h2);
        check("t2_pre_udata", a_udata, 64'h2222);
        tick();
        for (int i = 0; i < 4; i++) begin
            req_valid = 2'b11; a_res_vld = 1'b1; tid = 3'(i); res = 64'(100 + i);
            #2;
            check("t2_ready", 64'(a_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
            check("t2_rsp", 64'(a_rsp_vld), (i % 2 == 0) ? 64'h2 : 64'h1);
            check("t2_tid", 64'(a_rsp_tid), 64'(i));
            tick();
        end
        req_valid = 2'b00; tid = 3'd7;
        #2;
        check("t2_last_rsp", 64'(a_rsp_vld), 64'h2);
        tick();
        a_res_vld = 1'b0;
        #2;
        check("t2_busy", 64'(a_busy), 64'h0);

        // Divider single-outstanding rule
        req_valid = 2'b01; req_is_div = 2'b01;
        #2;
        check("t3_div0_ready", 64'(a_ready), 64'h1);
        tick();
        req_valid = 2'b10; req_is_div = 2'b10;
        #2;
        check("t3_div1_blocked", 64'(a_ready), 64'h0);
        tick();
        a_res_vld = 1'b1;
        #2;
        check("t3_div0_rsp", 64'(a_rsp_vld), 64'h1);
        check("t3_div1_still_blocked", 64'(a_ready), 64'h0);
        tick();
        a_res_vld = 1'b0;
        #2;
        check("t3_div1_ready", 64'(a_ready), 64'h2);
        tick();

        // Multiply overtakes the outstanding port-1 divide
        req_valid = 2'b01; req_is_div = 2'b00;
        #2;
        check("t4_mul_ready", 64'(a_ready), 64'h1);
        tick();
        req_valid = 2'b00; a_res_vld = 1'b1;
        #2;
        check("t4_mul_rsp", 64'(a_rsp_vld), 64'h1);
        tick();
        #2;
        check("t4_div_rsp", 64'(a_rsp_vld), 64'h2);
        tick();
        a_res_vld = 1'b0;
        #2;
        check("t4_busy", 64'(a_busy), 64'h0);
        check("t4_err", 64'(a_err), 64'h0);
        unit_ready = 1'b0; req_valid = 2'b10; req_is_div = 2'b10;
        #2;
        check("t4_unit_not_ready", 64'(a_ready), 64'h0);
        unit_ready = 1'b1;
        #1;
        check("t4_div_free", 64'(a_ready), 64'h2);
        tick();
        req_valid = 2'b00; a_res_vld = 1'b1;
        #2;
        check("t4_div2_rsp", 64'(a_rsp_vld), 64'h2);
        tick();
        a_res_vld = 1'b0;

        // Asynchronous reset clears instance b's error, set by the unanswered grants above
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_b_err", 64'(b_err), 64'h0);
        check("async_rst_b_busy", 64'(b_busy), 64'h0);
        tick();
        rst_n = 1'b1;

        // MAX_OUT=4, MUL_LAT=3 on instance b: one div then three muls fill port 0
        req_valid = 2'b01; req_is_div = 2'b01;
        #2;
        check("t5_div_ready", 64'(b_ready), 64'h1);
        check("t5_udata", b_udata, 64'h1111);
        tick();
        req_is_div = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("t5_mul_ready", 64'(b_ready), 64'h1);
            tick();
        end
        b_res_vld = 1'b1; res = 64'hBEEF; tid = 3'd2;
        #2;
        check("t5_full_blocked", 64'(b_ready), 64'h0);
        check("t5_rsp1", 64'(b_rsp_vld), 64'h1);
        check("t5_res", b_rsp_res, 64'hBEEF);
        check("t5_tid", 64'(b_rsp_tid), 64'h2);
        tick();
        #2;
        check("t5_slot_freed_ready", 64'(b_ready), 64'h1);
        check("t5_rsp2", 64'(b_rsp_vld), 64'h1);
        tick();
        req_valid = 2'b00;
        #2;
        check("t5_rsp3", 64'(b_rsp_vld), 64'h1);
        tick();
        #2;
        check("t5_div_rsp", 64'(b_rsp_vld), 64'h1);
        tick();
        #2;
        check("t5_rsp_last", 64'(b_rsp_vld), 64'h1);
        check("t5_busy_before", 64'(b_busy), 64'h1);
        tick();
        b_res_vld = 1'b0;
        #2;
        check("t5_busy", 64'(b_busy), 64'h0);
        check("t5_err", 64'(b_err), 64'h0);

        // Flush with two muls and one div outstanding
        req_valid = 2'b01;
        #2;
        check("t6_mul0_ready", 64'(b_ready), 64'h1);
        tick();
        #2;
        check("t6_mul1_ready", 64'(b_ready), 64'h1);
        tick();
        req_valid = 2'b10; req_is_div = 2'b10;
        #2;
        check("t6_div_ready", 64'(b_ready), 64'h2);
        tick();
        flush = 1'b1; req_valid = 2'b11; req_is_div = 2'b00; b_res_vld = 1'b1;
        #2;
        check("t6_flush_ready", 64'(b_ready), 64'h0);
        check("t6_flush_uvalid", 64'(b_uvalid), 64'h0);
        check("t6_flush_rsp", 64'(b_rsp_vld), 64'h0);
        tick();
        flush = 1'b0; req_valid = 2'b00; b_res_vld = 1'b0;
        #2;
        check("t6_busy", 64'(b_busy), 64'h0);
        check("t6_err_clean", 64'(b_err), 64'h0);
        b_res_vld = 1'b1;
        #2;
        check("t6_stray_rsp", 64'(b_rsp_vld), 64'h0);
        tick();
        b_res_vld = 1'b0;
        #2;
        check("t6_err_set", 64'(b_err), 64'h1);
        repeat (3) tick();
        check("t6_err_sticky", 64'(b_err), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t6_err_rst", 64'(b_err), 64'h0);
        tick();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
